// File: rtl/opcode_pkg.sv
// Shared constants, prefix classes and FSM state type for the Z80 opcode-boundary tracker.
// OPCODE_RETN_EN: when defined, RETN and its ED-prefixed mirrors also count as ISR returns.
package opcode_pkg;

    localparam logic [2:0] PFX_NONE = 3'd0;
    localparam logic [2:0] PFX_CB   = 3'd1;
    localparam logic [2:0] PFX_ED   = 3'd2;
    localparam logic [2:0] PFX_DD   = 3'd3;
    localparam logic [2:0] PFX_FD   = 3'd4;
    localparam logic [2:0] PFX_DDCB = 3'd5;
    localparam logic [2:0] PFX_FDCB = 3'd6;

    localparam logic [7:0] OP_CB   = 8'hCB;
    localparam logic [7:0] OP_ED   = 8'hED;
    localparam logic [7:0] OP_DD   = 8'hDD;
    localparam logic [7:0] OP_FD   = 8'hFD;
    localparam logic [7:0] OP_RETI = 8'h4D;
    localparam logic [7:0] OP_RETN = 8'h45;

    typedef enum logic [2:0] {
        StNormal,
        StPrefixCb,
        StPrefixEd,
        StPrefixIx,
        StPrefixIy
    } state_t;

    // Second byte of an ED-prefixed instruction that returns from an ISR.
    function automatic logic is_isr_return(input logic [7:0] b);
`ifdef OPCODE_RETN_EN
        // 01xx x101 covers RETN (45), RETI (4D) and the mirrors 55/5D/65/6D/75/7D.
        return (b[7:6] == 2'b01) && (b[2:0] == 3'b101) && (b != OP_RETN || b == OP_RETN);
`else
        return b == OP_RETI;
`endif
    endfunction

endpackage

// File: rtl/bus_sync.sv
// Multi-stage synchroniser for one asynchronous, active-low bus strobe; resets to idle (1).
module bus_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/opcode_tracker.sv
// Z80 opcode-boundary tracker: classifies M1 cycles, follows prefix chains, tracks ISR depth.
// OPCODE_RETN_EN (see opcode_pkg): also treat RETN and its mirrors as ISR returns.
module opcode_tracker
    import opcode_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEPTH_W     = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_data,
    input  logic               i_m1_n,
    input  logic               i_mreq_n,
    input  logic               i_iorq_n,
    input  logic               i_rd_n,
    output logic               o_at_boundary,
    output logic               o_insn_done,
    output logic [7:0]         o_opcode,
    output logic [2:0]         o_prefix,
    output logic               o_int_ack,
    output logic [DEPTH_W-1:0] o_isr_depth,
    output logic               o_isr_exit
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    logic w_m1_n;
    logic w_mreq_n;
    logic w_iorq_n;
    logic w_rd_n;

    bus_sync #(.STAGES(SYNC_STAGES)) u_sync_m1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_m1_n), .o_sync(w_m1_n));
    bus_sync #(.STAGES(SYNC_STAGES)) u_sync_mreq (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_mreq_n), .o_sync(w_mreq_n));
    bus_sync #(.STAGES(SYNC_STAGES)) u_sync_iorq (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_iorq_n), .o_sync(w_iorq_n));
    bus_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_rd_n), .o_sync(w_rd_n));

    logic w_fetch;
    logic w_ack;
    logic w_m1_rise;

    state_t             r_state;
    logic               r_m1_prev;
    logic               r_seen_fetch;
    logic               r_seen_ack;
    logic [7:0]         r_data;
    logic               r_at_boundary;
    logic               r_insn_done;
    logic [7:0]         r_opcode;
    logic [2:0]         r_prefix;
    logic               r_int_ack;
    logic [DEPTH_W-1:0] r_isr_depth;
    logic               r_isr_exit;

    assign w_fetch   = !w_m1_n && !w_mreq_n && !w_rd_n;
    assign w_ack     = !w_m1_n && !w_iorq_n;
    assign w_m1_rise = w_m1_n && !r_m1_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StNormal;
            r_m1_prev     <= 1'b1;
            r_seen_fetch  <= 1'b0;
            r_seen_ack    <= 1'b0;
            r_data        <= 8'h00;
            r_at_boundary <= 1'b1;
            r_insn_done   <= 1'b0;
            r_opcode      <= 8'h00;
            r_prefix      <= PFX_NONE;
            r_int_ack     <= 1'b0;
            r_isr_depth   <= '0;
            r_isr_exit    <= 1'b0;
        end else begin
            r_insn_done <= 1'b0;
            r_int_ack   <= 1'b0;
            r_isr_exit  <= 1'b0;
            r_m1_prev   <= w_m1_n;
            if (w_fetch) begin
                r_data <= i_data;
            end
            // Qualification is remembered across the M1 cycle and consumed by its rising edge.
            if (w_m1_rise) begin
                r_seen_fetch <= 1'b0;
                r_seen_ack   <= 1'b0;
            end else begin
                if (w_fetch) r_seen_fetch <= 1'b1;
                if (w_ack)   r_seen_ack   <= 1'b1;
            end

            if (w_m1_rise && r_seen_ack) begin
                r_int_ack <= 1'b1;
                if (r_isr_depth != DEPTH_MAX) begin
                    r_isr_depth <= r_isr_depth + 1'b1;
                end
            end else if (w_m1_rise && r_seen_fetch) begin
                unique case (r_state)
                    StNormal: begin
                        if (r_data == OP_CB || r_data == OP_ED ||
                            r_data == OP_DD || r_data == OP_FD) begin
                            r_at_boundary <= 1'b0;
                            r_state       <= (r_data == OP_CB) ? StPrefixCb :
                                             (r_data == OP_ED) ? StPrefixEd :
                                             (r_data == OP_DD) ? StPrefixIx : StPrefixIy;
                        end else begin
                            r_at_boundary <= 1'b1;
                            r_insn_done   <= 1'b1;
                            r_opcode      <= r_data;
                            r_prefix      <= PFX_NONE;
                        end
                    end
                    StPrefixCb, StPrefixEd: begin
                        r_state       <= StNormal;
                        r_at_boundary <= 1'b1;
                        r_insn_done   <= 1'b1;
                        r_opcode      <= r_data;
                        r_prefix      <= (r_state == StPrefixCb) ? PFX_CB : PFX_ED;
                        if (r_state == StPrefixEd && is_isr_return(r_data) &&
                            r_isr_depth != '0) begin
                            r_isr_depth <= r_isr_depth - 1'b1;
                            r_isr_exit  <= 1'b1;
                        end
                    end
                    StPrefixIx, StPrefixIy: begin
                        if (r_data == OP_DD) begin
                            r_state <= StPrefixIx;
                        end else if (r_data == OP_FD) begin
                            r_state <= StPrefixIy;
                        end else if (r_data == OP_ED) begin
                            r_state <= StPrefixEd;
                        end else begin
                            // DD/FD-CB ends the M1 sequence; displacement and opcode are plain reads.
                            r_state       <= StNormal;
                            r_at_boundary <= 1'b1;
                            r_insn_done   <= 1'b1;
                            r_opcode      <= r_data;
                            if (r_data == OP_CB) begin
                                r_prefix <= (r_state == StPrefixIx) ? PFX_DDCB : PFX_FDCB;
                            end else begin
                                r_prefix <= (r_state == StPrefixIx) ? PFX_DD : PFX_FD;
                            end
                        end
                    end
                    default: begin
                        r_state       <= StNormal;
                        r_at_boundary <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_at_boundary = r_at_boundary;
    assign o_insn_done   = r_insn_done;
    assign o_opcode      = r_opcode;
    assign o_prefix      = r_prefix;
    assign o_int_ack     = r_int_ack;
    assign o_isr_depth   = r_isr_depth;
    assign o_isr_exit    = r_isr_exit;

endmodule

// File: tb/tb_opcode_tracker.sv
// Directed, table-driven bench for opcode_tracker; honours OPCODE_RETN_EN for the RETN case.
module tb_opcode_tracker;

`ifdef OPCODE_RETN_EN
    localparam bit RETN_EN = 1'b1;
`else
    localparam bit RETN_EN = 1'b0;
`endif

    localparam int KFETCH = 0;
    localparam int KACK   = 1;
    localparam int KREAD  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1;
    logic       at_boundary, insn_done, int_ack, isr_exit;
    logic [7:0] opcode;
    logic [2:0] prefix;
    logic [2:0] isr_depth;

    opcode_tracker #(.SYNC_STAGES(2), .DEPTH_W(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_m1_n(m1_n), .i_mreq_n(mreq_n),
        .i_iorq_n(iorq_n), .i_rd_n(rd_n), .o_at_boundary(at_boundary),
        .o_insn_done(insn_done), .o_opcode(opcode), .o_prefix(prefix),
        .o_int_ack(int_ack), .o_isr_depth(isr_depth), .o_isr_exit(isr_exit));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;
    int cnt_done = 0, cnt_ack = 0, cnt_exit = 0;

    always @(negedge clk) begin
        if (insn_done) cnt_done++;
        if (int_ack)   cnt_ack++;
        if (isr_exit)  cnt_exit++;
    end

    typedef struct {
        int         kind;
        logic [7:0] b;
        logic       atb;
        logic [7:0] op;
        logic [2:0] pfx;
        logic [2:0] dep;
        int         dd;
        int         da;
        int         de;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int kind, logic [7:0] b, logic atb, logic [7:0] op,
                                logic [2:0] pfx, logic [2:0] dep, int dd, int da, int de);
        vec_t v;
        v.kind = kind; v.b = b; v.atb = atb; v.op = op; v.pfx = pfx; v.dep = dep;
        v.dd = dd; v.da = da; v.de = de;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_pins();
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic do_op(input int kind, input logic [7:0] b);
        @(negedge clk);
        data = b;
        if (kind == KFETCH) begin
            m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
        end else if (kind == KACK) begin
            m1_n = 1'b0; iorq_n = 1'b0;
        end else if (kind == KREAD) begin
            mreq_n = 1'b0; rd_n = 1'b0;
        end else begin
            m1_n = 1'b0;  // bare M1 glitch, neither fetch nor ack
        end
        repeat (3) @(negedge clk);
        idle_pins();
        repeat (6) @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic atb, input logic [7:0] op,
                               input logic [2:0] pfx, input logic [2:0] dep);
        check({tag, ".at_boundary"}, int'(at_boundary), int'(atb));
        check({tag, ".opcode"}, int'(opcode), int'(op));
        check({tag, ".prefix"}, int'(prefix), int'(pfx));
        check({tag, ".isr_depth"}, int'(isr_depth), int'(dep));
    endtask

    initial begin
        logic [2:0] d21;
        logic [2:0] dmodel;
        int         d0, a0, e0;

        d21 = RETN_EN ? 3'd0 : 3'd1;
        vecs.push_back(mk(KFETCH, 8'h3E, 1, 8'h3E, 0, 0, 1, 0, 0));
        vecs.push_back(mk(KFETCH, 8'h00, 1, 8'h00, 0, 0, 1, 0, 0));
        vecs.push_back(mk(KFETCH, 8'hDD, 0, 8'h00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(KFETCH, 8'hCB, 1, 8'hCB, 5, 0, 1, 0, 0));
        vecs.push_back(mk(KREAD,  8'h05, 1, 8'hCB, 5, 0, 0, 0, 0));
        vecs.push_back(mk(KREAD,  8'h46, 1, 8'hCB, 5, 0, 0, 0, 0));
        vecs.push_back(mk(KFETCH, 8'hDD, 0, 8'hCB, 5, 0, 0, 0, 0));
        vecs.push_back(mk(KFETCH, 8'hFD, 0, 8'hCB, 5, 0, 0, 0, 0));
        vecs.push_back(mk(KFETCH, 8'hED, 0, 8'hCB, 5, 0, 0, 0, 0));
        vecs.push_back(mk(KFETCH, 8'hB0, 1, 8'hB0, 2, 0, 1, 0, 0));
        vecs.push_back(mk(KACK,   8'hFF, 1, 8'hB0, 2, 1, 0, 1, 0));
        vecs.push_back(mk(KACK,   8'hFF, 1, 8'hB0, 2, 2, 0, 1, 0));
        vecs.push_back(mk(KFETCH, 8'hED, 0, 8'hB0, 2, 2, 0, 0, 0));
        vecs.push_back(mk(KFETCH, 8'h4D, 1, 8'h4D, 2, 1, 1, 0, 1));
        vecs.push_back(mk(KFETCH, 8'hED, 0, 8'h4D, 2, 1, 0, 0, 0));
        vecs.push_back(mk(KFETCH, 8'h4D, 1, 8'h4D, 2, 0, 1, 0, 1));
        vecs.push_back(mk(KFETCH, 8'hED, 0, 8'h4D, 2, 0, 0, 0, 0));
        vecs.push_back(mk(KFETCH, 8'h4D, 1, 8'h4D, 2, 0, 1, 0, 0));
        vecs.push_back(mk(KACK,   8'hFF, 1, 8'h4D, 2, 1, 0, 1, 0));
        vecs.push_back(mk(KFETCH, 8'hED, 0, 8'h4D, 2, 1, 0, 0, 0));
        vecs.push_back(mk(KFETCH, 8'h45, 1, 8'h45, 2, d21, 1, 0, RETN_EN ? 1 : 0));
        vecs.push_back(mk(KFETCH, 8'hFD, 0, 8'h45, 2, d21, 0, 0, 0));
        vecs.push_back(mk(KFETCH, 8'hCB, 1, 8'hCB, 6, d21, 1, 0, 0));
        vecs.push_back(mk(KFETCH, 8'hCB, 0, 8'hCB, 6, d21, 0, 0, 0));
        vecs.push_back(mk(KFETCH, 8'h11, 1, 8'h11, 1, d21, 1, 0, 0));
        vecs.push_back(mk(KFETCH, 8'hDD, 0, 8'h11, 1, d21, 0, 0, 0));
        vecs.push_back(mk(KACK,   8'hFF, 0, 8'h11, 1, d21 + 3'd1, 0, 1, 0));
        vecs.push_back(mk(KFETCH, 8'h21, 1, 8'h21, 3, d21 + 3'd1, 1, 0, 0));

        idle_pins();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_state("reset", 1'b1, 8'h00, 3'd0, 3'd0);
        check("reset.insn_done", int'(insn_done), 0);
        check("reset.int_ack", int'(int_ack), 0);
        check("reset.isr_exit", int'(isr_exit), 0);

        // Exact latency: pulse appears SYNC_STAGES+1 clocks after the /M1 pin rises.
        @(negedge clk);
        data = 8'h77; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
        repeat (3) @(negedge clk);
        idle_pins();
        @(negedge clk);
        check("lat.clk1", int'(insn_done), 0);
        @(negedge clk);
        check("lat.clk2", int'(insn_done), 0);
        @(negedge clk);
        check("lat.clk3", int'(insn_done), 1);
        check("lat.opcode", int'(opcode), 8'h77);
        @(negedge clk);
        check("lat.clk4", int'(insn_done), 0);
        repeat (3) @(negedge clk);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            d0 = cnt_done; a0 = cnt_ack; e0 = cnt_exit;
            do_op(vecs[i].kind, vecs[i].b);
            check_state(tag, vecs[i].atb, vecs[i].op, vecs[i].pfx, vecs[i].dep);
            check({tag, ".insn_done"}, cnt_done - d0, vecs[i].dd);
            check({tag, ".int_ack"}, cnt_ack - a0, vecs[i].da);
            check({tag, ".isr_exit"}, cnt_exit - e0, vecs[i].de);
        end

        // Bare /M1 pulse with no qualifying strobe must be ignored.
        d0 = cnt_done; a0 = cnt_ack;
        do_op(3, 8'hCB);
        check_state("glitch", 1'b1, 8'h21, 3'd3, d21 + 3'd1);
        check("glitch.pulses", (cnt_done - d0) + (cnt_ack - a0), 0);

        // Depth saturates at 7 while int_ack keeps pulsing.
        dmodel = d21 + 3'd1;
        for (int k = 0; k < 8; k++) begin
            a0 = cnt_ack;
            do_op(KACK, 8'hFF);
            dmodel = (dmodel == 3'd7) ? 3'd7 : dmodel + 3'd1;
            check($sformatf("sat%0d.depth", k), int'(isr_depth), int'(dmodel));
            check($sformatf("sat%0d.int_ack", k), cnt_ack - a0, 1);
        end

        // Reset in the middle of a prefix chain.
        do_op(KFETCH, 8'hDD);
        check("midrst.pre", int'(at_boundary), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_state("midrst", 1'b1, 8'h00, 3'd0, 3'd0);
        d0 = cnt_done;
        do_op(KFETCH, 8'h21);
        check_state("postrst", 1'b1, 8'h21, 3'd0, 3'd0);
        check("postrst.insn_done", cnt_done - d0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
